signed_divider: RTL

Sequential signed integer divider. It is the inverse-operation companion to the team's sequential Booth multiplier and uses the same start/done handshake, so both units can share a controller. It computes an N-bit truncating quotient and remainder using one restoring-division step per clock on operand magnitudes, followed by a sign-fix cycle. It sits beside the multiplier in the arithmetic datapath.

---
 rtl/arith_pkg.sv | 13 +
 rtl/div_step.sv | 25 ++
 rtl/signed_divider.sv | 113 +++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic datapath types and width constants
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    localparam int DIV_N_DEFAULT = 5;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step on magnitudes
module div_step #(
    parameter int N = 5
) (
    input  logic [N:0]   rem,
    input  logic [N-1:0] dvd,
    input  logic [N-1:0] dmag,
    output logic [N:0]   rem_next,
    output logic [N-1:0] dvd_next,
    output logic         qbit
);

    logic [N+1:0] shifted;
    logic [N+1:0] trial;

    // One guard bit above the N+1 bit remainder makes the trial sign unambiguous.
    always_comb begin
        shifted  = {rem, dvd[N-1]};
        trial    = shifted - {2'b00, dmag};
        qbit     = ~trial[N+1];
        rem_next = qbit ? trial[N:0] : shifted[N:0];
        dvd_next = {dvd[N-2:0], qbit};
    end

endmodule

// File: rtl/signed_divider.sv
// rtl/signed_divider.sv - sequential signed restoring divider with start/done handshake
module signed_divider
    import arith_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done,
    output logic         busy,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = $clog2(N + 1);

    div_state_t    state;
    logic [CW-1:0] cnt;
    logic [N:0]    rem;
    logic [N-1:0]  dvd;
    logic [N-1:0]  dmag;
    logic          sign_q;
    logic          sign_r;
    logic          dz;
    logic          ov;

    logic [N:0]    rem_next;
    logic [N-1:0]  dvd_next;
    logic          qbit;
    logic [N-1:0]  dividend_abs;
    logic [N-1:0]  divisor_abs;

    // The most negative value maps onto itself, which reads as 2^(N-1) unsigned.
    assign dividend_abs = dividend[N-1] ? -dividend : dividend;
    assign divisor_abs  = divisor[N-1]  ? -divisor  : divisor;

    div_step #(.N(N)) u_step (
        .rem      (rem),
        .dvd      (dvd),
        .dmag     (dmag),
        .rem_next (rem_next),
        .dvd_next (dvd_next),
        .qbit     (qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            dvd         <= '0;
            dmag        <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            ov          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        sign_q      <= dividend[N-1] ^ divisor[N-1];
                        sign_r      <= dividend[N-1];
                        dvd         <= dividend_abs;
                        dmag        <= divisor_abs;
                        rem         <= '0;
                        cnt         <= '0;
                        dz          <= (divisor == '0);
                        ov          <= (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
                        quotient    <= '0;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    dvd <= dvd_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1))
                        state <= FIX;
                end
                FIX: begin
                    // A zero divisor leaves |dividend| in rem, so the remainder restores the dividend.
                    quotient    <= dz ? '0 : (sign_q ? -dvd : dvd);
                    remainder   <= sign_r ? -rem[N-1:0] : rem[N-1:0];
                    div_by_zero <= dz;
                    overflow    <= ov;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
